// File: rtl/prog_mem_loader.sv
// prog_mem_loader: owns the instruction memory. Zero-sweeps it after reset,
// takes host program writes, then releases the core and serves registered
// instruction fetches until the host halts it.
module prog_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_w,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  input  logic              halt,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_run,
  output logic [ADDR_W:0]   word_cnt,
  output logic              wr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_SWEEP, ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                r_prog_ready;
  logic                r_cpu_run;
  logic [DATA_W-1:0]   r_instr;
  logic [ADDR_W:0]     r_word_cnt;
  logic                r_wr_err;

  logic                w_loading;
  logic                w_acc;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  assign w_loading = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_acc     = prog_w && w_loading;

  // Single write port: the sweep owns it while clearing, the host otherwise.
  assign w_we    = (r_state == ST_SWEEP) || w_acc;
  assign w_waddr = (r_state == ST_SWEEP) ? r_ptr : prog_addr;
  assign w_wdata = (r_state == ST_SWEEP) ? '0 : prog_data;

  // Next-state decode; prog_last only matters alongside an accepted write.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_SWEEP: if (&r_ptr) w_nxt = ST_IDLE;
      ST_IDLE,
      ST_LOAD:  if (prog_w) w_nxt = prog_last ? ST_RUN : ST_LOAD;
      ST_RUN:   if (halt) w_nxt = ST_IDLE;
      default:  w_nxt = ST_SWEEP;
    endcase
  end

  // FSM state, sweep pointer and all registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state      <= ST_SWEEP;
      r_ptr        <= '0;
      r_prog_ready <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_instr      <= '0;
      r_word_cnt   <= '0;
      r_wr_err     <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_ptr        <= (r_state == ST_SWEEP) ? r_ptr + 1'b1 : '0;
      r_prog_ready <= (w_nxt == ST_IDLE) || (w_nxt == ST_LOAD);
      r_cpu_run    <= (w_nxt == ST_RUN);
      // Writes outside the load window are dropped but flagged.
      r_wr_err     <= prog_w && !w_loading;
      // Gating to zero outside RUN hides any same-cycle write/read overlap.
      r_instr      <= (r_state == ST_RUN) ? r_mem[fetch_addr] : '0;
      if ((r_state == ST_RUN) && halt)
        r_word_cnt <= '0;
      else if (w_acc && !(&r_word_cnt))
        r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // Instruction memory write port; contents are defined by the sweep, not reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign prog_ready = r_prog_ready;
  assign cpu_run    = r_cpu_run;
  assign instr      = r_instr;
  assign word_cnt   = r_word_cnt;
  assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: reset/sweep timing, load/run/halt
// vector table, wr_err cases, mid-load reset and word counter saturation.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        clr;
  logic        prog_w;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        prog_last;
  logic        prog_ready;
  logic        halt;
  logic [7:0]  fetch_addr;
  logic [31:0] instr;
  logic        cpu_run;
  logic [8:0]  word_cnt;
  logic        wr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_mem_loader #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .clr(clr), .prog_w(prog_w), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
    .halt(halt), .fetch_addr(fetch_addr), .instr(instr), .cpu_run(cpu_run),
    .word_cnt(word_cnt), .wr_err(wr_err)
  );

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic        last;
    logic        hlt;
    logic [7:0]  f;
    logic        rdy;
    logic        run;
    logic [8:0]  cnt;
    logic [31:0] ins;
    logic        err;
  } vec_t;

  function automatic vec_t mk(logic w, logic [7:0] a, logic [31:0] d, logic last,
                              logic hlt, logic [7:0] f, logic rdy, logic run,
                              logic [8:0] cnt, logic [31:0] ins, logic err);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.last = last; v.hlt = hlt; v.f = f;
    v.rdy = rdy; v.run = run; v.cnt = cnt; v.ins = ins; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One rejected write during the sweep, then count cycles until prog_ready.
  task automatic sweep_wait();
    int n;
    prog_w = 1'b1; prog_addr = 8'h44; prog_data = 32'h5555_AAAA;
    tick();
    n = 1;
    chk("sweep_wr_err", wr_err, 1);
    chk("sweep_ready_low", prog_ready, 0);
    prog_w = 1'b0;
    tick();
    n++;
    chk("sweep_wr_err_clear", wr_err, 0);
    while (!prog_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("sweep_len", n, 256);
    chk("sweep_run", cpu_run, 0);
    chk("sweep_cnt", word_cnt, 0);
  endtask

  logic [31:0] w [8];
  logic [31:0] m [8];
  vec_t vt[$];

  initial begin
    w[0] = 32'h2008_0005; w[1] = 32'h2009_0006; w[2] = 32'h012A_4020;
    w[3] = 32'hAC0A_0000; w[4] = 32'h8C0B_0000; w[5] = 32'h1000_FFFF;
    w[6] = 32'h0171_6022; w[7] = 32'h0000_0008;

    // Load 0..7, last on 7.
    for (int i = 0; i < 7; i++)
      vt.push_back(mk(1, 8'(i), w[i], 0, 0, 0, 1, 0, 9'(i + 1), 0, 0));
    vt.push_back(mk(1, 7, w[7], 1, 0, 0, 0, 1, 8, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 8, w[3], 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8, 0, 1, 8, 0, 0));
    // Host write while running: flagged, not written.
    vt.push_back(mk(1, 2, 32'hDEAD_BEEF, 0, 0, 2, 0, 1, 8, w[2], 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1, 8, w[2], 0));
    // Halt: last cycle of RUN still fetches.
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, w[0], 0));
    // prog_last without prog_w does nothing.
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(1, 2, 32'h1234_5678, 1, 0, 0, 0, 1, 1, 0, 0));
    // Halt together with a write: still flagged, not written.
    vt.push_back(mk(1, 5, 32'hFFFF_FFFF, 0, 1, 2, 1, 0, 0, 32'h1234_5678, 1));
    vt.push_back(mk(1, 2, 32'h1234_5678, 1, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 8; i++) m[i] = w[i];
    m[2] = 32'h1234_5678;
    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 0, 0, 0, 0, 8'(i), 0, 1, 1, m[i], 0));

    clr = 1'b0; prog_w = 1'b0; prog_addr = '0; prog_data = '0;
    prog_last = 1'b0; halt = 1'b0; fetch_addr = '0;
    tick(); tick();
    chk("rst_ready", prog_ready, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_instr", instr, 0);
    chk("rst_err", wr_err, 0);
    clr = 1'b1;
    sweep_wait();

    foreach (vt[k]) begin
      prog_w = vt[k].w; prog_addr = vt[k].a; prog_data = vt[k].d;
      prog_last = vt[k].last; halt = vt[k].hlt; fetch_addr = vt[k].f;
      tick();
      chk($sformatf("v%0d_ready", k), prog_ready, vt[k].rdy);
      chk($sformatf("v%0d_run", k), cpu_run, vt[k].run);
      chk($sformatf("v%0d_cnt", k), word_cnt, vt[k].cnt);
      chk($sformatf("v%0d_instr", k), instr, vt[k].ins);
      chk($sformatf("v%0d_err", k), wr_err, vt[k].err);
    end
    prog_w = 0; prog_last = 0; halt = 0;

    // Reset in the middle of a load.
    halt = 1; tick(); halt = 0;
    for (int i = 0; i < 4; i++) begin
      prog_w = 1; prog_addr = 8'(10 + i); prog_data = 32'hA000_0000 + i;
      tick();
    end
    prog_w = 0;
    chk("mid_load_cnt", word_cnt, 4);
    chk("mid_load_ready", prog_ready, 1);
    clr = 1'b0;
    #2;
    chk("async_rst_cnt", word_cnt, 0);
    chk("async_rst_ready", prog_ready, 0);
    chk("async_rst_run", cpu_run, 0);
    #2 clr = 1'b1;
    sweep_wait();
    prog_w = 1; prog_addr = 8'hFF; prog_data = 32'hCAFE_F00D; prog_last = 1;
    tick();
    prog_w = 0; prog_last = 0;
    chk("reload_run", cpu_run, 1);
    chk("reload_cnt", word_cnt, 1);
    fetch_addr = 8'd10; tick(); chk("resweep_a10", instr, 0);
    fetch_addr = 8'd2;  tick(); chk("resweep_a2", instr, 0);
    fetch_addr = 8'hFF; tick(); chk("reload_a255", instr, 32'hCAFE_F00D);

    // Counter: 300 writes, then saturation.
    halt = 1; tick(); halt = 0;
    chk("halt_cnt", word_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      prog_w = 1; prog_addr = 8'(i); prog_data = 32'(i);
      tick();
    end
    chk("cnt_300", word_cnt, 300);
    chk("cnt_300_run", cpu_run, 0);
    chk("cnt_300_ready", prog_ready, 1);
    for (int i = 0; i < 211; i++) tick();
    chk("cnt_511", word_cnt, 511);
    tick();
    chk("cnt_sat", word_cnt, 511);
    prog_w = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
